// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue
//   Instruction fetch front end for the pipelined MIPS32 core. Issues word
//   reads to instruction memory over a req/ack handshake, buffers returned
//   instructions with their next-PC in a small FIFO, and hands them to ID
//   through valid/ready. A taken-branch redirect flushes the queue and
//   restarts fetch at the target.
//
//   Optional feature macro: FETCH_HLT_STOP_EN -- an enqueued HLT word
//   (opcode 6'b111111) sets a sticky stop flag that blocks further requests
//   until the next redirect or reset.
//
// Ports
//   clk1, rst_n             clock (rising edge), async active-low reset
//   imem_req/imem_addr      read request and word address (PC[ADDR_W-1:0])
//   imem_ack/imem_rdata     read completion and instruction word
//   redirect_valid/_pc      taken branch pulse and target word address
//   halt                    level; blocks new requests while high
//   ir_valid/ir/npc         head entry valid, instruction, PC+1
//   ir_ready                ID consumes the head when ir_valid & ir_ready
//   level                   occupied FIFO entries
//
// State   | meaning
// IDLE    | nothing outstanding; issue when space, no halt, no stop
// REQ     | live request at pc_q, waiting for ack
// DISCARD | request orphaned by a redirect; its data is thrown away
module mips32_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt,
  output logic                   ir_valid,
  output logic [31:0]            ir,
  output logic [31:0]            npc,
  input  logic                   ir_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       target_q, target_d;
  logic [31:0]       pc_inc;
  logic [31:0]       ir_mem_q  [DEPTH];
  logic [31:0]       npc_mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              push, pop;
  logic              can_issue;
  logic              stop_active;

  assign pc_inc = pc_q + 32'd1;

`ifdef FETCH_HLT_STOP_EN
  logic stop_q, stop_d;

  always_comb begin
    stop_d = stop_q;
    if (redirect_valid) begin
      stop_d = 1'b0;
    end else if (push && (imem_rdata[31:26] == 6'b111111)) begin
      stop_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
    end
  end

  assign stop_active = stop_q;
`else
  assign stop_active = 1'b0;
`endif

  // Only one request is ever outstanding and IDLE has none, so the space
  // check reduces to the stored count.
  assign can_issue = !halt && !stop_active && (count_q < FULL_CNT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    push     = 1'b0;
    if (redirect_valid) begin
      target_d = redirect_pc;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          // Queue is being flushed and stop cleared, so only halt can block.
          pc_d = redirect_pc;
          if (!halt) state_d = ST_REQ;
        end else if (can_issue) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            // Old request retired this edge: go straight to the target so
            // the new request is visible in the very next cycle.
            pc_d    = redirect_pc;
            state_d = halt ? ST_IDLE : ST_REQ;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_inc;
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_pc : target_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Redirect wins over any pop in the same cycle.
  assign pop = (count_q != '0) && ir_ready && !redirect_valid;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ir_mem_q  <= '{default: '0};
      npc_mem_q <= '{default: '0};
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        ir_mem_q[wr_ptr_q]  <= imem_rdata;
        npc_mem_q[wr_ptr_q] <= pc_inc;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = pc_q[ADDR_W-1:0];
  assign ir_valid  = (count_q != '0);
  assign ir        = ir_mem_q[rd_ptr_q];
  assign npc       = npc_mem_q[rd_ptr_q];
  assign level     = count_q;

endmodule
